// File: rtl/gfx_line_pkg.sv
// Shared types for the Bresenham line drawer: FSM states, command bundle, error width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gfx_line_pkg;

  // Default framebuffer geometry; cmd_t is sized from these
  localparam int GFX_H_VISIBLE  = 640;
  localparam int GFX_V_VISIBLE  = 480;
  localparam int GFX_PIXEL_BITS = 12;
  localparam int GFX_X_BITS     = $clog2(GFX_H_VISIBLE);
  localparam int GFX_Y_BITS     = $clog2(GFX_V_VISIBLE);

  // Signed error term: widest coordinate plus sign bit plus headroom for dx+dy
  function automatic int err_bits(input int x_bits, input int y_bits);
    return ((x_bits > y_bits) ? x_bits : y_bits) + 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [GFX_X_BITS-1:0]     x0;
    logic [GFX_Y_BITS-1:0]     y0;
    logic [GFX_X_BITS-1:0]     x1;
    logic [GFX_Y_BITS-1:0]     y1;
    logic [GFX_PIXEL_BITS-1:0] color;
  } cmd_t;

endpackage

// File: rtl/gfx_line_drawer.sv
// Rasterises one line command with integer Bresenham, one pixel per clock to the display writer.
// Latency: command handshake in cycle N -> first gfx_valid in cycle N+2; done one cycle after the last pixel.
// Backpressure: gfx_valid && !gfx_ready freezes position/err; GFX_LINE_DRAWER_CLIP_EN steps off-screen pixels silently.
module gfx_line_drawer
  import gfx_line_pkg::*;
#(
  parameter int  H_VISIBLE  = GFX_H_VISIBLE,
  parameter int  V_VISIBLE  = GFX_V_VISIBLE,
  parameter int  PIXEL_BITS = GFX_PIXEL_BITS,
  localparam int FB_X_BITS  = $clog2(H_VISIBLE),
  localparam int FB_Y_BITS  = $clog2(V_VISIBLE),
  localparam int ERR_BITS   = err_bits(FB_X_BITS, FB_Y_BITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FB_X_BITS-1:0]  cmd_x0,
  input  logic [FB_Y_BITS-1:0]  cmd_y0,
  input  logic [FB_X_BITS-1:0]  cmd_x1,
  input  logic [FB_Y_BITS-1:0]  cmd_y1,
  input  logic [PIXEL_BITS-1:0] cmd_color,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [FB_X_BITS-1:0]  gfx_x,
  output logic [FB_Y_BITS-1:0]  gfx_y,
  output logic [PIXEL_BITS-1:0] gfx_color,
  output logic                  gfx_valid,
  input  logic                  gfx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [FB_X_BITS-1:0] X_ONE = FB_X_BITS'(1);
  localparam logic [FB_Y_BITS-1:0] Y_ONE = FB_Y_BITS'(1);

`ifdef GFX_LINE_DRAWER_CLIP_EN
  // One extra bit so a power-of-two width still compares correctly
  localparam logic [FB_X_BITS:0] X_LIM = (FB_X_BITS+1)'(H_VISIBLE);
  localparam logic [FB_Y_BITS:0] Y_LIM = (FB_Y_BITS+1)'(V_VISIBLE);
`endif

  state_t                       state_q, state_d;
  cmd_t                         cmd_q, cmd_d;
  logic signed [ERR_BITS-1:0]   dx_q, dx_d;
  logic signed [ERR_BITS-1:0]   dy_q, dy_d;
  logic signed [ERR_BITS-1:0]   err_q, err_d;
  logic                         sx_neg_q, sx_neg_d;
  logic                         sy_neg_q, sy_neg_d;
  logic [FB_X_BITS-1:0]         x_q, x_d;
  logic [FB_Y_BITS-1:0]         y_q, y_d;
  logic [PIXEL_BITS-1:0]        color_q, color_d;
  logic                         valid_q, valid_d;
  logic                         done_q, done_d;

  // Step datapath intermediates
  logic [FB_X_BITS-1:0]         dx_abs;
  logic [FB_Y_BITS-1:0]         dy_abs;
  logic signed [ERR_BITS:0]     e2;
  logic                         step_x, step_y, at_end, advance;
  logic                         vis_first, vis_next;
  logic signed [ERR_BITS-1:0]   err_n;
  logic [FB_X_BITS-1:0]         x_n;
  logic [FB_Y_BITS-1:0]         y_n;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign gfx_x     = x_q;
  assign gfx_y     = y_q;
  assign gfx_color = color_q;
  assign gfx_valid = valid_q;
  assign done      = done_q;

  // Next-state: command capture, Bresenham setup, and one Bresenham step per advance
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    valid_d  = valid_q;
    done_d   = 1'b0;

    dx_abs = (cmd_q.x1 >= cmd_q.x0) ? (cmd_q.x1 - cmd_q.x0) : (cmd_q.x0 - cmd_q.x1);
    dy_abs = (cmd_q.y1 >= cmd_q.y0) ? (cmd_q.y1 - cmd_q.y0) : (cmd_q.y0 - cmd_q.y1);
    at_end = (x_q == cmd_q.x1) && (y_q == cmd_q.y1);

    // Both decisions use the pre-update err; e2 has one extra bit so 2*err cannot overflow
    e2     = $signed({err_q, 1'b0});
    step_x = (e2 >= $signed({dy_q[ERR_BITS-1], dy_q}));
    step_y = (e2 <= $signed({dx_q[ERR_BITS-1], dx_q}));
    err_n  = err_q;
    if (step_x) err_n = err_n + dy_q;
    if (step_y) err_n = err_n + dx_q;
    x_n = x_q;
    if (step_x) x_n = sx_neg_q ? (x_q - X_ONE) : (x_q + X_ONE);
    y_n = y_q;
    if (step_y) y_n = sy_neg_q ? (y_q - Y_ONE) : (y_q + Y_ONE);

`ifdef GFX_LINE_DRAWER_CLIP_EN
    // Off-screen points are never offered, so they step without waiting for gfx_ready
    vis_first = ({1'b0, cmd_q.x0} < X_LIM) && ({1'b0, cmd_q.y0} < Y_LIM);
    vis_next  = ({1'b0, x_n} < X_LIM) && ({1'b0, y_n} < Y_LIM);
    advance   = !valid_q || gfx_ready;
`else
    vis_first = 1'b1;
    vis_next  = 1'b1;
    advance   = valid_q && gfx_ready;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.x0    = cmd_x0;
          cmd_d.y0    = cmd_y0;
          cmd_d.x1    = cmd_x1;
          cmd_d.y1    = cmd_y1;
          cmd_d.color = cmd_color;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        dx_d     = $signed({{(ERR_BITS-FB_X_BITS){1'b0}}, dx_abs});
        dy_d     = -$signed({{(ERR_BITS-FB_Y_BITS){1'b0}}, dy_abs});
        err_d    = $signed({{(ERR_BITS-FB_X_BITS){1'b0}}, dx_abs})
                 - $signed({{(ERR_BITS-FB_Y_BITS){1'b0}}, dy_abs});
        sx_neg_d = !(cmd_q.x0 < cmd_q.x1);
        sy_neg_d = !(cmd_q.y0 < cmd_q.y1);
        x_d      = cmd_q.x0;
        y_d      = cmd_q.y0;
        color_d  = cmd_q.color;
        valid_d  = vis_first;
        state_d  = DRAW;
      end
      DRAW: begin
        if (advance) begin
          // End test precedes the step, so coordinates never wrap past the endpoint
          if (at_end) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = err_n;
            x_d     = x_n;
            y_d     = y_n;
            valid_d = vis_next;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; async reset abandons any line in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_gfx_line_drawer.sv
// Directed bench for gfx_line_drawer: hand-computed pixel sequences, latency, backpressure, reset, clipping.
// Outputs are sampled 1ns after the rising edge; inputs are driven at that same point.
// Cycle indices below count from the cycle after the command handshake (0 = SETUP, 1 = first pixel).
`timescale 1ns/1ps
module tb_gfx_line_drawer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  cmd_x0, cmd_x1;
  logic [8:0]  cmd_y0, cmd_y1;
  logic [11:0] cmd_color;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  gfx_x;
  logic [8:0]  gfx_y;
  logic [11:0] gfx_color;
  logic        gfx_valid;
  logic        gfx_ready;
  logic        busy;
  logic        done;

  gfx_line_drawer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .gfx_x     (gfx_x),
    .gfx_y     (gfx_y),
    .gfx_color (gfx_color),
    .gfx_valid (gfx_valid),
    .gfx_ready (gfx_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Captured handshakes of the most recent line
  int px [32];
  int py [32];
  int pc [32];
  int hs [32];
  int npix;
  int done_cyc;
  bit done_seen;
  bit rdy_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic [9:0] x0, input logic [8:0] y0,
                          input logic [9:0] x1, input logic [8:0] y1,
                          input logic [11:0] col);
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_x1    = x1;
    cmd_y1    = y1;
    cmd_color = col;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("setup_valid_low", {31'd0, gfx_valid}, 32'd0);
    chk("setup_busy", {31'd0, busy}, 32'd1);
  endtask

  // Records every handshake until done; optionally stalls the pixel with index stall_idx
  task automatic collect(input int budget, input int stall_idx, input int stall_len);
    int stalled;
    logic [9:0] snap_x;
    logic [8:0] snap_y;
    stalled   = 0;
    snap_x    = '0;
    snap_y    = '0;
    npix      = 0;
    done_cyc  = -1;
    done_seen = 1'b0;
    rdy_at_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (npix == stall_idx && stalled < stall_len && (stalled > 0 || gfx_valid)) begin
        gfx_ready = 1'b0;
        if (stalled == 0) begin
          snap_x = gfx_x;
          snap_y = gfx_y;
        end else begin
          chk("stall_valid", {31'd0, gfx_valid}, 32'd1);
          chk("stall_x", {22'd0, gfx_x}, {22'd0, snap_x});
          chk("stall_y", {23'd0, gfx_y}, {23'd0, snap_y});
        end
        stalled++;
      end else begin
        gfx_ready = 1'b1;
      end
      if (gfx_valid && gfx_ready && npix < 32) begin
        px[npix] = int'(gfx_x);
        py[npix] = int'(gfx_y);
        pc[npix] = int'(gfx_color);
        hs[npix] = c;
        npix++;
      end
      if (done) begin
        done_seen   = 1'b1;
        done_cyc    = c;
        rdy_at_done = cmd_ready;
        break;
      end
      @(posedge clk); #1;
    end
    gfx_ready = 1'b1;
    chk("done_within_budget", {31'd0, done_seen}, 32'd1);
  endtask

  initial begin
    int ex[5];
    int ey[5];
    int bp_hs[4];
    int clip_n;

    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    cmd_valid = 1'b0;
    gfx_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;

    // Reset state
    chk("rst_gfx_valid", {31'd0, gfx_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_done",      {31'd0, done}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_gfx_x",     {22'd0, gfx_x}, 32'd0);
    chk("rst_gfx_y",     {23'd0, gfx_y}, 32'd0);
    chk("rst_gfx_color", {20'd0, gfx_color}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Horizontal (0,0)->(3,0): pixels on cycles 1..4, done on cycle 5
    send_cmd(10'd0, 9'd0, 10'd3, 9'd0, 12'h5A5);
    collect(40, -1, 0);
    chk("h_npix", npix, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("h_x",     px[i], i);
      chk("h_y",     py[i], 32'd0);
      chk("h_color", pc[i], 32'h5A5);
      chk("h_cycle", hs[i], i + 1);
    end
    chk("h_done_cycle",  done_cyc, 32'd5);
    chk("h_ready_at_done", {31'd0, rdy_at_done}, 32'd1);
    @(posedge clk); #1;
    chk("h_done_pulse_one", {31'd0, done}, 32'd0);
    chk("h_idle_busy",      {31'd0, busy}, 32'd0);

    // Single point (7,9)->(7,9)
    send_cmd(10'd7, 9'd9, 10'd7, 9'd9, 12'hF00);
    collect(40, -1, 0);
    chk("pt_npix",  npix, 32'd1);
    chk("pt_x",     px[0], 32'd7);
    chk("pt_y",     py[0], 32'd9);
    chk("pt_color", pc[0], 32'hF00);
    chk("pt_cycle", hs[0], 32'd1);
    chk("pt_done_cycle", done_cyc, 32'd2);

    // Steep reverse (5,5)->(2,1)
    ex = '{5, 4, 3, 3, 2};
    ey = '{5, 4, 3, 2, 1};
    send_cmd(10'd5, 9'd5, 10'd2, 9'd1, 12'h0F0);
    collect(40, -1, 0);
    chk("steep_npix", npix, 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("steep_x", px[i], ex[i]);
      chk("steep_y", py[i], ey[i]);
    end
    chk("steep_done_cycle", done_cyc, 32'd6);

    // Backpressure: (1,0) held for 3 cycles
    bp_hs = '{1, 5, 6, 7};
    send_cmd(10'd0, 9'd0, 10'd3, 9'd0, 12'h00F);
    collect(40, 1, 3);
    chk("bp_npix", npix, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_x",     px[i], i);
      chk("bp_cycle", hs[i], bp_hs[i]);
    end
    chk("bp_done_cycle", done_cyc, 32'd8);

    // Right-edge line (637,0)->(642,0): clipped build offers only 637..639
`ifdef GFX_LINE_DRAWER_CLIP_EN
    clip_n = 3;
`else
    clip_n = 6;
`endif
    send_cmd(10'd637, 9'd0, 10'd642, 9'd0, 12'h0AB);
    collect(40, -1, 0);
    chk("edge_npix", npix, clip_n);
    for (int i = 0; i < clip_n; i++) begin
      chk("edge_x",     px[i], 637 + i);
      chk("edge_cycle", hs[i], i + 1);
    end
    chk("edge_done_cycle", done_cyc, 32'd7);

    // Reset mid-line during pixel x=2 of (0,0)->(10,0)
    send_cmd(10'd0, 9'd0, 10'd10, 9'd0, 12'h123);
    gfx_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_valid_before", {31'd0, gfx_valid}, 32'd1);
    chk("mid_x_before",     {22'd0, gfx_x}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_valid_async", {31'd0, gfx_valid}, 32'd0);
    chk("mid_done",        {31'd0, done}, 32'd0);
    chk("mid_busy",        {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {30'd0, done, gfx_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Fresh command after reset: (1,1)->(3,2) gives (1,1),(2,2),(3,2)
    send_cmd(10'd1, 9'd1, 10'd3, 9'd2, 12'hABC);
    collect(40, -1, 0);
    chk("after_npix", npix, 32'd3);
    chk("after_x0", px[0], 32'd1);
    chk("after_y0", py[0], 32'd1);
    chk("after_x1", px[1], 32'd2);
    chk("after_y1", py[1], 32'd2);
    chk("after_x2", px[2], 32'd3);
    chk("after_y2", py[2], 32'd2);
    chk("after_color", pc[2], 32'hABC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
